// File: rtl/lcd_write_ctrl.sv
// HD44780-style 4-bit LCD write controller.
// Arbitrates the bus between the init sequencer and a byte write path.
module lcd_write_ctrl #(
  parameter int T_SETUP     = 4,
  parameter int T_EPW       = 25,
  parameter int T_NIB_GAP   = 100,
  parameter int T_EXEC      = 4000,
  parameter int T_EXEC_LONG = 152000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       init_done,
  input  logic [3:0] init_db,
  input  logic       init_rs,
  input  logic       init_rw,
  input  logic       init_e,
  input  logic       req_valid,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       req_ready,
  output logic [3:0] lcd_db,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, SETUP_H, EPW_H, GAP, SETUP_L, EPW_L, EXEC
  } state_t;

  localparam logic [17:0] C_SETUP = 18'(T_SETUP - 1);
  localparam logic [17:0] C_EPW   = 18'(T_EPW - 1);
  localparam logic [17:0] C_GAP   = 18'(T_NIB_GAP - 1);
  localparam logic [17:0] C_EXEC  = 18'(T_EXEC - 1);
  localparam logic [17:0] C_LONG  = 18'(T_EXEC_LONG - 1);

  state_t      state_q, state_d;
  logic [17:0] cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic [3:0]  db_q, db_d;
  logic        lrs_q, lrs_d;
  logic        rw_q, rw_d;
  logic        e_q, e_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        long_cmd;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rs_d     = rs_q;
    data_d   = data_q;
    owner_d  = owner_q | (init_done & (state_q == IDLE));
    long_cmd = !rs_q && (data_q == 8'h01 || data_q == 8'h02
                         || data_q == 8'h03);

    if (state_q == IDLE) begin
      if (req_valid && ready_q) begin
        rs_d    = req_rs;
        data_d  = req_data;
        state_d = SETUP_H;
        cnt_d   = C_SETUP;
      end
    end else if (cnt_q != 18'd0) begin
      cnt_d = cnt_q - 18'd1;
    end else begin
      unique case (state_q)
        SETUP_H: begin state_d = EPW_H;   cnt_d = C_EPW;   end
        EPW_H:   begin state_d = GAP;     cnt_d = C_GAP;   end
        GAP:     begin state_d = SETUP_L; cnt_d = C_SETUP; end
        SETUP_L: begin state_d = EPW_L;   cnt_d = C_EPW;   end
        EPW_L: begin
          state_d = EXEC;
          cnt_d   = long_cmd ? C_LONG : C_EXEC;
        end
        default: begin state_d = IDLE; cnt_d = 18'd0; end
      endcase
    end

    // Outputs track the next state so the pins are registered.
    db_d  = db_q;
    lrs_d = lrs_q;
    rw_d  = 1'b0;
    e_d   = 1'b0;
    if (!owner_d) begin
      db_d  = init_db;
      lrs_d = init_rs;
      rw_d  = init_rw;
      e_d   = init_e;
    end else begin
      unique case (state_d)
        SETUP_H, EPW_H, GAP: begin
          db_d  = data_d[7:4];
          lrs_d = rs_d;
        end
        SETUP_L, EPW_L, EXEC: begin
          db_d  = data_d[3:0];
          lrs_d = rs_d;
        end
        default: ;
      endcase
      e_d = (state_d == EPW_H) || (state_d == EPW_L);
    end

    ready_d = owner_d && (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 18'd0;
      owner_q <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'd0;
      db_q    <= 4'd0;
      lrs_q   <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      db_q    <= db_d;
      lrs_q   <= lrs_d;
      rw_q    <= rw_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign lcd_db    = db_q;
  assign lcd_rs    = lrs_q;
  assign lcd_rw    = rw_q;
  assign lcd_e     = e_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed bench for lcd_write_ctrl with shortened timing parameters.
// Busy length = 2*TS + 2*TE + TG + exec wait.
module tb_lcd_write_ctrl;

  localparam int TS = 2;
  localparam int TE = 3;
  localparam int TG = 5;
  localparam int TX = 7;
  localparam int TL = 20;
  localparam int NORM = 2 * TS + 2 * TE + TG + TX;
  localparam int LONG = 2 * TS + 2 * TE + TG + TL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done = 1'b0;
  logic [3:0] init_db = 4'd0;
  logic       init_rs = 1'b0;
  logic       init_rw = 1'b0;
  logic       init_e = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic [7:0] req_data = 8'd0;
  logic       req_ready;
  logic [3:0] lcd_db;
  logic       lcd_rs, lcd_rw, lcd_e, busy;

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;

  lcd_write_ctrl #(
    .T_SETUP(TS), .T_EPW(TE), .T_NIB_GAP(TG),
    .T_EXEC(TX), .T_EXEC_LONG(TL)
  ) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_db(init_db), .init_rs(init_rs), .init_rw(init_rw),
    .init_e(init_e), .req_valid(req_valid), .req_rs(req_rs),
    .req_data(req_data), .req_ready(req_ready), .lcd_db(lcd_db),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       done;
    logic [3:0] db;
    logic       rs, rw, e, valid;
    logic [3:0] xdb;
    logic       xrs, xrw, xe, xrdy;
  } vec_t;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Bus-stability watcher: DB/RS must not move with E or while E is high.
  logic [3:0] p_db;
  logic       p_rs, p_e, p_ok = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mon_en && p_ok) begin
      checks++;
      if ((lcd_db !== p_db || lcd_rs !== p_rs)
          && (lcd_e !== p_e || lcd_e === 1'b1)) begin
        errors++;
        $display("FAIL bus_stable: db %0h->%0h rs %0b->%0b e %0b->%0b",
                 p_db, lcd_db, p_rs, lcd_rs, p_e, lcd_e);
      end
    end
    p_db = lcd_db;
    p_rs = lcd_rs;
    p_e  = lcd_e;
    p_ok = mon_en;
  end

  task automatic handshake(input logic rs, input logic [7:0] d,
                           input logic hold);
    int n = 0;
    while (!req_ready && n < 100) begin
      step();
      n++;
    end
    chk("ready_wait", int'(n < 100), 1);
    req_valid = 1'b1;
    req_rs    = rs;
    req_data  = d;
    step();
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic watch(input string tag, input int exp_busy,
                       input logic [3:0] hi, input logic [3:0] lo,
                       input logic ers);
    int n = 0, pulses = 0, w = 0, w0 = 0, w1 = 0, bad = 0;
    logic [3:0] d0 = 4'd0, d1 = 4'd0;
    while (busy && n < 400) begin
      if (lcd_e) begin
        if (w == 0) begin
          if (pulses == 0) d0 = lcd_db;
          else d1 = lcd_db;
        end
        w++;
        if (lcd_rs !== ers || lcd_rw !== 1'b0) bad++;
      end else if (w != 0) begin
        if (pulses == 0) w0 = w;
        else w1 = w;
        pulses++;
        w = 0;
      end
      n++;
      step();
    end
    chk({tag, "_busy_len"}, n, exp_busy);
    chk({tag, "_pulses"}, pulses, 2);
    chk({tag, "_epw_h"}, w0, TE);
    chk({tag, "_epw_l"}, w1, TE);
    chk({tag, "_db_hi"}, int'(d0), int'(hi));
    chk({tag, "_db_lo"}, int'(d1), int'(lo));
    chk({tag, "_rs_rw"}, bad, 0);
    chk({tag, "_ready_back"}, int'(req_ready), 1);
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};

    init_db = 4'hF;
    init_e  = 1'b1;
    step();
    step();
    chk("rst_db", int'(lcd_db), 0);
    chk("rst_e", int'(lcd_e), 0);
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      init_done = tbl[i].done;
      init_db   = tbl[i].db;
      init_rs   = tbl[i].rs;
      init_rw   = tbl[i].rw;
      init_e    = tbl[i].e;
      req_valid = tbl[i].valid;
      step();
      chk($sformatf("vec%0d_db", i), int'(lcd_db), int'(tbl[i].xdb));
      chk($sformatf("vec%0d_rs", i), int'(lcd_rs), int'(tbl[i].xrs));
      chk($sformatf("vec%0d_rw", i), int'(lcd_rw), int'(tbl[i].xrw));
      chk($sformatf("vec%0d_e", i), int'(lcd_e), int'(tbl[i].xe));
      chk($sformatf("vec%0d_ready", i), int'(req_ready), int'(tbl[i].xrdy));
    end
    init_e  = 1'b0;
    init_rw = 1'b0;
    mon_en  = 1'b1;

    handshake(1'b1, 8'h41, 1'b0);
    watch("w41", NORM, 4'h4, 4'h1, 1'b1);
    handshake(1'b0, 8'h01, 1'b0);
    watch("clr", LONG, 4'h0, 4'h1, 1'b0);
    handshake(1'b0, 8'h0C, 1'b0);
    watch("c0c", NORM, 4'h0, 4'hC, 1'b0);
    handshake(1'b0, 8'h03, 1'b0);
    watch("c03", LONG, 4'h0, 4'h3, 1'b0);
    handshake(1'b0, 8'h04, 1'b0);
    watch("c04", NORM, 4'h0, 4'h4, 1'b0);
    handshake(1'b1, 8'h01, 1'b0);
    watch("d01", NORM, 4'h0, 4'h1, 1'b1);

    handshake(1'b1, 8'h48, 1'b1);
    req_data = 8'h49;
    watch("b48", NORM, 4'h4, 4'h8, 1'b1);
    step();
    chk("b2b_accept", int'(busy), 1);
    req_valid = 1'b0;
    watch("b49", NORM, 4'h4, 4'h9, 1'b1);

    init_done = 1'b0;
    init_db   = 4'hF;
    init_rs   = 1'b0;
    init_rw   = 1'b1;
    init_e    = 1'b1;
    step();
    step();
    chk("sticky_db", int'(lcd_db), 9);
    chk("sticky_e", int'(lcd_e), 0);
    chk("sticky_rw", int'(lcd_rw), 0);
    chk("sticky_ready", int'(req_ready), 1);
    handshake(1'b0, 8'h0C, 1'b0);
    watch("s0c", NORM, 4'h0, 4'hC, 1'b0);
    init_e  = 1'b0;
    init_rw = 1'b0;
    init_db = 4'h0;

    handshake(1'b1, 8'h55, 1'b0);
    begin
      int n = 0;
      while (!lcd_e && n < 50) begin
        step();
        n++;
      end
      chk("epw_reach", int'(lcd_e), 1);
    end
    mon_en = 1'b0;
    rst = 1'b1;
    step();
    chk("abort_db", int'(lcd_db), 0);
    chk("abort_rs", int'(lcd_rs), 0);
    chk("abort_e", int'(lcd_e), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(req_ready), 0);
    chk("abort_owner", int'(dut.owner_q), 0);
    rst = 1'b0;
    step();
    step();
    step();
    chk("no_owner_ready", int'(req_ready), 0);
    chk("no_owner_busy", int'(busy), 0);
    init_done = 1'b1;
    step();
    chk("reacq_ready", int'(req_ready), 1);
    mon_en = 1'b1;
    handshake(1'b1, 8'h41, 1'b0);
    watch("r41", NORM, 4'h4, 4'h1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
